// File: rtl/inv_shift_rows_stream_if.sv
// Byte stream channel: valid/ready handshake carrying one AES state byte and an end-of-state flag.
interface inv_shift_rows_stream_if;
  localparam int unsigned DATA_W = 8;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  // Producer side of the channel.
  modport master (output valid, output data, output last, input ready);
  // Consumer side of the channel.
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES (Inv)ShiftRows: collects a 16-byte state in column-major order,
// then replays it with each row rotated. INVERSE=1 rotates row r right by r,
// INVERSE=0 rotates it left by r. Input and output phases never overlap.
module inv_shift_rows_stream #(
  parameter bit INVERSE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inv_shift_rows_stream_if.slave  s,
  inv_shift_rows_stream_if.master m,
  output logic                   err
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q [DEPTH];
  logic [DATA_W-1:0] buf_d [DEPTH];

  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              m_last_q,  m_last_d;
  logic              err_q,     err_d;

  logic s_xfer_c;
  logic m_xfer_c;

  assign s_xfer_c = s.valid & s_ready_q;
  assign m_xfer_c = m_valid_q & m.ready;

  // Buffer slot feeding output position j: same row, column shifted by the row index.
  function automatic logic [CNT_W-1:0] src_idx(input logic [CNT_W-1:0] j);
    logic [1:0] c;
    logic [1:0] r;
    logic [1:0] src_c;
    c     = j[3:2];
    r     = j[1:0];
    src_c = INVERSE ? 2'(c - r) : 2'(c + r);
    return {src_c, r};
  endfunction

  // State, counter, buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  // Next state: byte capture with framing checks in FILL, index advance in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    unique case (state_q)
      FILL: begin
        if (s_xfer_c) begin
          if (s.last && (cnt_q != CNT_MAX)) begin
            // Early end of state: drop the partial state and restart.
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            buf_d[cnt_q] = s.data;
            if (cnt_q == CNT_MAX) begin
              // Missing end marker is flagged but the state is still processed.
              err_d   = ~s.last;
              state_d = DRAIN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (m_xfer_c) begin
          if (cnt_q == CNT_MAX) begin
            state_d = FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from next state so they switch with it.
  always_comb begin
    s_ready_d = 1'b0;
    m_valid_d = 1'b0;
    m_data_d  = '0;
    m_last_d  = 1'b0;
    if (state_d == FILL) begin
      s_ready_d = 1'b1;
    end else begin
      m_valid_d = 1'b1;
      m_data_d  = buf_d[src_idx(cnt_d)];
      m_last_d  = (cnt_d == CNT_MAX);
    end
  end

  assign s.ready = s_ready_q;
  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;
  assign m.last  = m_last_q;
  assign err     = err_q;

endmodule
